// File: rtl/alu_arbiter_if.sv
// Request/result bus between two ALU requesters, the arbiter and a result consumer.
// The master side drives requests and acknowledges results; the slave side is the arbiter.
interface alu_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  req0;
    logic                  req1;
    logic [2:0]            oc0;
    logic [2:0]            oc1;
    logic [DATA_WIDTH-1:0] a0;
    logic [DATA_WIDTH-1:0] b0;
    logic [DATA_WIDTH-1:0] a1;
    logic [DATA_WIDTH-1:0] b1;
    logic                  gnt0;
    logic                  gnt1;
    logic [DATA_WIDTH-1:0] res;
    logic                  res_id;
    logic                  res_err;
    logic                  res_valid;
    logic                  res_ack;

    modport master (
        output req0, req1, oc0, oc1, a0, b0, a1, b1, res_ack,
        input  gnt0, gnt1, res, res_id, res_err, res_valid
    );

    modport slave (
        input  req0, req1, oc0, oc1, a0, b0, a1, b1, res_ack,
        output gnt0, gnt1, res, res_id, res_err, res_valid
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared multi-cycle ALU.
// One operation is in flight at a time; the result is held until acknowledged.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    localparam int unsigned W = DATA_WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic           ptr;
    logic           sel_q;
    logic           stage_q;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;

    logic           sel_c;
    logic [W-1:0]   calc_c;
    logic           err_c;

    // Lone requester wins outright; on contention the pointer decides.
    always_comb begin
        sel_c = bus.req1;
        if (bus.req0 && bus.req1) begin
            sel_c = ptr;
        end
    end

    // ALU on the captured operands; division by zero saturates and flags.
    always_comb begin
        calc_c = '0;
        err_c  = 1'b0;
        case (op_q)
            OP_ADD: calc_c = a_q + b_q;
            OP_SUB: calc_c = a_q - b_q;
            OP_MUL: calc_c = W'(a_q * b_q);
            OP_DIV: begin
                if (b_q == '0) begin
                    calc_c = '1;
                    err_c  = 1'b1;
                end else begin
                    calc_c = a_q / b_q;
                end
            end
            OP_NOT: calc_c = ~a_q;
            OP_XOR: calc_c = a_q ^ b_q;
            OP_OR:  calc_c = a_q | b_q;
            OP_AND: calc_c = a_q & b_q;
            default: calc_c = '0;
        endcase
    end

    // EXEC spends one cycle registering the ALU output, a second raising res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            sel_q         <= 1'b0;
            stage_q       <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.res       <= '0;
            bus.res_id    <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.res_valid <= 1'b0;
        end else begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        sel_q    <= sel_c;
                        op_q     <= sel_c ? bus.oc1 : bus.oc0;
                        a_q      <= sel_c ? bus.a1  : bus.a0;
                        b_q      <= sel_c ? bus.b1  : bus.b0;
                        bus.gnt0 <= ~sel_c;
                        bus.gnt1 <= sel_c;
                        stage_q  <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stage_q) begin
                        bus.res     <= calc_c;
                        bus.res_err <= err_c;
                        bus.res_id  <= sel_q;
                        stage_q     <= 1'b1;
                    end else begin
                        bus.res_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ack) begin
                        bus.res_valid <= 1'b0;
                        ptr           <= ~bus.res_id;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single operations plus
// contention, latency, operand-capture and mid-operation reset sequences.
module tb_alu_arbiter;
    localparam int unsigned W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(W)) bus ();

    alu_arbiter #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic         id;
        logic [2:0]   oc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic [2:0] oc,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            bus.req1 = v; bus.oc1 = oc; bus.a1 = a; bus.b1 = b;
        end else begin
            bus.req0 = v; bus.oc0 = oc; bus.a0 = a; bus.b0 = b;
        end
    endtask

    task automatic wait_gnt(input logic id, output bit got);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if ((id ? bus.gnt1 : bus.gnt0) === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"},  32'(bus.gnt0), 0);
        check({tag, "_gnt1"},  32'(bus.gnt1), 0);
        check({tag, "_valid"}, 32'(bus.res_valid), 0);
        check({tag, "_res"},   32'(bus.res), 0);
        check({tag, "_id"},    32'(bus.res_id), 0);
        check({tag, "_err"},   32'(bus.res_err), 0);
    endtask

    task automatic quiet_window(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) seen = 1'b1;
        end
        check({tag, "_no_result"}, 32'(seen), 0);
    endtask

    // Full transaction; granted requester's inputs are scrambled after the grant.
    task automatic run_op(input string tag, input vec_t v);
        bit got;
        @(negedge clk);
        set_req(v.id, 1'b1, v.oc, v.a, v.b);
        wait_gnt(v.id, got);
        check({tag, "_gnt"}, 32'(got), 1);
        if (!got) begin
            set_req(v.id, 1'b0, v.oc, v.a, v.b);
            return;
        end
        check({tag, "_other_gnt"}, 32'(v.id ? bus.gnt0 : bus.gnt1), 0);
        set_req(v.id, 1'b0, ~v.oc, ~v.a, v.b + 16'h5a5a);
        wait_valid(got);
        check({tag, "_valid"}, 32'(got), 1);
        check({tag, "_res"},   32'(bus.res), 32'(v.exp_res));
        check({tag, "_id"},    32'(bus.res_id), 32'(v.id));
        check({tag, "_err"},   32'(bus.res_err), 32'(v.exp_err));
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.res_valid), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit   got;
        bit   both;
        int   gids [4];
        int   gcyc [4];
        int   ng;
        vec_t v;

        vecs[0]  = '{1'b0, 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 3'b010, 16'd300,  16'd300,  16'd24464, 1'b0};
        vecs[2]  = '{1'b1, 3'b011, 16'd9,    16'd0,    16'hFFFF, 1'b1};
        vecs[3]  = '{1'b1, 3'b011, 16'd20,   16'd3,    16'd6,    1'b0};
        vecs[4]  = '{1'b0, 3'b001, 16'd3,    16'd5,    16'hFFFE, 1'b0};
        vecs[5]  = '{1'b1, 3'b100, 16'h00FF, 16'h1234, 16'hFF00, 1'b0};
        vecs[6]  = '{1'b0, 3'b101, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0};
        vecs[7]  = '{1'b1, 3'b110, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0};
        vecs[8]  = '{1'b0, 3'b111, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0};
        vecs[9]  = '{1'b0, 3'b011, 16'd7,    16'd7,    16'd1,    1'b0};
        vecs[10] = '{1'b1, 3'b000, 16'h1234, 16'h1111, 16'h2345, 1'b0};
        vecs[11] = '{1'b0, 3'b010, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0};

        bus.req0 = 0; bus.req1 = 0; bus.oc0 = 0; bus.oc1 = 0;
        bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0; bus.res_ack = 0;

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single add with latency and hold-without-ack checks.
        @(negedge clk);
        set_req(1'b0, 1'b1, 3'b000, 16'd5, 16'd7);
        @(negedge clk);
        check("single_gnt0", 32'(bus.gnt0), 1);
        check("single_gnt1", 32'(bus.gnt1), 0);
        set_req(1'b0, 1'b0, 3'b000, 16'd5, 16'd7);
        @(negedge clk);
        check("single_gnt0_pulse", 32'(bus.gnt0), 0);
        check("single_valid_early", 32'(bus.res_valid), 0);
        @(negedge clk);
        check("single_valid", 32'(bus.res_valid), 1);
        check("single_res", 32'(bus.res), 12);
        check("single_id", 32'(bus.res_id), 0);
        check("single_err", 32'(bus.res_err), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("single_hold%0d_valid", i), 32'(bus.res_valid), 1);
            check($sformatf("single_hold%0d_res", i), 32'(bus.res), 12);
        end
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;
        check("single_valid_drop", 32'(bus.res_valid), 0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Contention from a known pointer: grants 0,1,0,1 spaced four cycles apart.
        pulse_reset();
        @(negedge clk);
        set_req(1'b0, 1'b1, 3'b000, 16'd1, 16'd2);
        set_req(1'b1, 1'b1, 3'b010, 16'd300, 16'd300);
        bus.res_ack = 1'b1;
        ng = 0;
        both = 1'b0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (bus.gnt0 && bus.gnt1) both = 1'b1;
            if (bus.gnt0 || bus.gnt1) begin
                gids[ng] = bus.gnt1 ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
            if (bus.res_valid)
                check("cont_res", 32'(bus.res), bus.res_id ? 32'd24464 : 32'd3);
        end
        check("cont_excl", 32'(both), 0);
        check("cont_ngrants", 32'(ng), 4);
        if (ng == 4) begin
            for (int k = 0; k < 4; k++) check($sformatf("cont_order%0d", k), 32'(gids[k]), 32'(k % 2));
            for (int k = 1; k < 4; k++) check($sformatf("cont_gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 4);
        end
        set_req(1'b0, 1'b0, 3'b000, 0, 0);
        set_req(1'b1, 1'b0, 3'b000, 0, 0);
        repeat (6) @(negedge clk);
        bus.res_ack = 1'b0;

        // Reset while in EXEC, with the pointer left at 1.
        v = '{1'b0, 3'b000, 16'd1, 16'd1, 16'd2, 1'b0};
        run_op("pre_exec", v);
        @(negedge clk);
        set_req(1'b1, 1'b1, 3'b001, 16'd10, 16'd3);
        wait_gnt(1'b1, got);
        check("exec_gnt", 32'(got), 1);
        set_req(1'b1, 1'b0, 3'b001, 16'd10, 16'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_exec");
        @(negedge clk);
        rst_n = 1'b1;
        quiet_window("rst_exec");

        // Reset while in DONE, again with the pointer at 1.
        run_op("pre_done", v);
        @(negedge clk);
        set_req(1'b1, 1'b1, 3'b001, 16'd10, 16'd3);
        wait_gnt(1'b1, got);
        set_req(1'b1, 1'b0, 3'b001, 16'd10, 16'd3);
        wait_valid(got);
        check("done_valid", 32'(got), 1);
        check("done_res", 32'(bus.res), 7);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_done");
        @(negedge clk);
        rst_n = 1'b1;
        quiet_window("rst_done");

        // First contended grant after reset must go to requester 0.
        set_req(1'b0, 1'b1, 3'b110, 16'h0F00, 16'h00F0);
        set_req(1'b1, 1'b1, 3'b111, 16'hFFFF, 16'h00FF);
        wait_gnt(1'b0, got);
        check("post_rst_gnt0", 32'(got), 1);
        check("post_rst_gnt1", 32'(bus.gnt1), 0);
        set_req(1'b0, 1'b0, 3'b000, 0, 0);
        set_req(1'b1, 1'b0, 3'b000, 0, 0);
        wait_valid(got);
        check("post_rst_res", 32'(bus.res), 32'h0FF0);
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
